iic_slave_regif: RTL
====================

# iic_slave_regif

I2C target (slave) with a byte-wide register-port back end. It decodes START/STOP, matches a 7-bit device address, ACKs, and takes a sub-address of ADDR_BYTE bytes. Write data goes out as register write strobes; read data is fetched through a read strobe and shifted onto SDA. The block sits on the board-side I2C pins and lets the on-chip I2C master, or an external host, configure FPGA-internal registers over the same bus protocol.

## Interface
- DEV_ADDR, 7'h3C: 7-bit device address to match.
- ADDR_BYTE, 1: sub-address bytes; legal values are 1 or 2.
- FILTER_LEN, 3: number of consecutive equal synced samples required before a filtered SCL/SDA value changes.
- clk  in  1  system clock; must be ≥20× SCL frequency.
- rst_n  in  1  reset, synchronous, active-low.
- scl_in  in  1  SCL pad input.
- sda_in  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad drives Z).
- reg_addr  out  ADDR_BYTE*8  current register address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wdata  out  8  write data; valid while reg_wr_en = 1.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; must be valid on the cycle after reg_rd_en.
- busy  out  1  high from START to STOP while addressed.

## Operation
- Input path: 2-FF sync, then the FILTER_LEN glitch filter, giving scl_f/sda_f. Edges of scl_f/sda_f are detected as one-cycle pulses.
- START: sda_f fall while scl_f = 1. STOP: sda_f rise while scl_f = 1. Both are recognised in every state and take priority over bit handling.
- Bits are sampled on the scl_f rise, MSB first. sda_oe changes only on the cycle after a scl_f fall.
- States:
  - IDLE → DEV on START.
  - DEV: shift 8 bits. If addr[7:1] == DEV_ADDR → ACK_DEV, else → WAIT_STOP with no ACK.
  - ACK_DEV: R/W = 0 → SUB (sub-byte count 0). R/W = 1 → RD.
  - SUB: shift 8 bits → ACK_SUB. The first byte loads reg_addr[7:0]; the second byte (ADDR_BYTE = 2) loads reg_addr[15:8].
  - ACK_SUB: → SUB while fewer than ADDR_BYTE bytes have been received, else → WR.
  - WR: shift 8 bits. On the 8th rise, pulse reg_wr_en with reg_wdata = byte and the current reg_addr. Next cycle reg_addr += 1 → ACK_WR → WR.
  - RD: drive bits (sda_oe = ~bit), then → MACK.
  - MACK: sample the master's bit. 0 (ACK): reg_addr += 1, pulse reg_rd_en the next cycle, load reg_rdata the cycle after → RD. 1 (NACK): → WAIT_STOP.
  - WAIT_STOP: sda_oe = 0; only START or STOP is acted on.
- Read prefetch: reg_rd_en pulses one cycle after the R/W-bit rise that matches with R = 1. reg_rdata is captured the following cycle, before the ACK-bit fall.
- ACK drive: sda_oe = 1 from the scl_f fall ending bit 8 to the scl_f fall ending bit 9, for ACK_DEV, ACK_SUB and ACK_WR.
- Repeated START in any state → DEV with the bit count cleared and reg_addr retained. This is what lets a write-sub-address-then-read sequence work.
- STOP in any state → IDLE with sda_oe = 0. A partial byte is discarded with no write strobe.
- Address arithmetic wraps modulo 2^(8*ADDR_BYTE): FF→00, or FFFF→0000.
- General call (address 0) is not supported. 10-bit addressing is not supported.

## Timing
- Reset values: sda_oe = 0, reg_addr = 0, reg_wr_en = 0, reg_wdata = 0, reg_rd_en = 0, busy = 0, state = IDLE, filters = 1.
- Pin-to-internal latency: 2 + FILTER_LEN clk cycles. Glitches shorter than FILTER_LEN cycles are suppressed.
- reg_wr_en: 1 cycle, one cycle after the detected 8th data-bit rise. reg_addr increments on the following cycle.
- reg_rd_en to reg_rdata capture: exactly 1 cycle.
- busy: set on the cycle the address matches. Cleared on STOP, on a mismatched address after a repeated START, and on reset.
- Reset mid-transfer: SDA is released immediately and no further strobes are issued.

## Test plan
- Write, ADDR_BYTE = 1: START, 0x78 (3C<<1|0), 0x12, 0xA5, STOP → ACK on 3 bytes; one reg_wr_en with addr 0x12 and data 0xA5; reg_addr = 0x13 afterwards.
- Burst write, ADDR_BYTE = 2: sub-address bytes 0xFF then 0xFF (addr 0xFFFF), data 0x01, 0x02 → writes land at 0xFFFF then 0x0000 (wrap).
- Combined read: write sub-address 0x20, repeated START, 0x79, read 2 bytes with ACK then NACK, regfile[0x20] = 0x5A, regfile[0x21] = 0xC3 → SDA shows 0x5A then 0xC3; reg_rd_en pulses twice; after the NACK the bus is released.
- Address mismatch: 0x70 → no ACK (SDA high at the 9th clock), no strobes, busy = 0, block idle after STOP.
- Abort: STOP after 4 data bits, and separately rst_n low mid-byte → no reg_wr_en; sda_oe = 0; a subsequent valid transfer succeeds.
- Glitch: a 2-cycle SDA low pulse while SCL is high, with FILTER_LEN = 3 → no START detected; the state remains IDLE.

Source files
------------

// File: rtl/iic_slave_regif.sv
// I2C target with a byte-wide register port: filtered pin inputs, START/STOP detection,
// 7-bit address match, ADDR_BYTE-byte sub-address, write strobes and prefetched reads.
module iic_slave_regif #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         ADDR_BYTE  = 1,
    parameter int         FILTER_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_oe,
    output logic [ADDR_BYTE*8-1:0] reg_addr,
    output logic                   reg_wr_en,
    output logic [7:0]             reg_wdata,
    output logic                   reg_rd_en,
    input  logic [7:0]             reg_rdata,
    output logic                   busy
);

    localparam int AW = ADDR_BYTE * 8;
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_ACK_DEV,
        ST_SUB,
        ST_ACK_SUB,
        ST_WR,
        ST_ACK_WR,
        ST_RD,
        ST_MACK,
        ST_WAIT_STOP
    } state_t;

    logic [1:0] pin_raw;
    logic [1:0] pin_f;

    assign pin_raw = {sda_in, scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic          meta_reg;
            logic          sync_reg;
            logic          filt_reg;
            logic [CW-1:0] cnt_reg;

            // The filtered value only follows the synced pin after FILTER_LEN disagreeing samples in a row.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    filt_reg <= 1'b1;
                    cnt_reg  <= '0;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                    if (sync_reg == filt_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                        filt_reg <= sync_reg;
                        cnt_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign pin_f[gi] = filt_reg;
        end
    endgenerate

    logic scl_f, sda_f;
    logic scl_d_reg, sda_d_reg;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = pin_f[0];
    assign sda_f     = pin_f[1];
    assign scl_rise  = scl_f & ~scl_d_reg;
    assign scl_fall  = ~scl_f & scl_d_reg;
    assign start_det = scl_f & ~sda_f & sda_d_reg;
    assign stop_det  = scl_f & sda_f & ~sda_d_reg;

    state_t          state_reg, state_next;
    logic [7:0]      rx_sh_reg;
    logic [7:0]      tx_sh_reg;
    logic [2:0]      bit_cnt_reg;
    logic [1:0]      sub_cnt_reg;
    logic            ack_on_reg;
    logic            rw_reg;
    logic            rd_cap_reg;
    logic            sda_oe_reg;
    logic [AW-1:0]   reg_addr_reg;
    logic            reg_wr_en_reg;
    logic [7:0]      reg_wdata_reg;
    logic            reg_rd_en_reg;
    logic            busy_reg;

    logic            byte_done;
    logic            addr_match;
    logic [7:0]      byte_in;

    assign byte_done  = scl_rise && (bit_cnt_reg == 3'd7);
    assign byte_in    = {rx_sh_reg[6:0], sda_f};
    assign addr_match = (rx_sh_reg[6:0] == DEV_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop_det) begin
            state_next = ST_IDLE;
        end else if (start_det) begin
            state_next = ST_DEV;
        end else begin
            case (state_reg)
                ST_DEV:     if (byte_done) state_next = addr_match ? ST_ACK_DEV : ST_WAIT_STOP;
                ST_ACK_DEV: if (scl_fall && ack_on_reg) state_next = rw_reg ? ST_RD : ST_SUB;
                ST_SUB:     if (byte_done) state_next = ST_ACK_SUB;
                ST_ACK_SUB: if (scl_fall && ack_on_reg)
                                state_next = (sub_cnt_reg == 2'(ADDR_BYTE)) ? ST_WR : ST_SUB;
                ST_WR:      if (byte_done) state_next = ST_ACK_WR;
                ST_ACK_WR:  if (scl_fall && ack_on_reg) state_next = ST_WR;
                ST_RD:      if (byte_done) state_next = ST_MACK;
                ST_MACK:    if (scl_rise) state_next = sda_f ? ST_WAIT_STOP : ST_RD;
                default:    state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_d_reg     <= 1'b1;
            sda_d_reg     <= 1'b1;
            rx_sh_reg     <= '0;
            tx_sh_reg     <= '0;
            bit_cnt_reg   <= '0;
            sub_cnt_reg   <= '0;
            ack_on_reg    <= 1'b0;
            rw_reg        <= 1'b0;
            rd_cap_reg    <= 1'b0;
            sda_oe_reg    <= 1'b0;
            reg_addr_reg  <= '0;
            reg_wr_en_reg <= 1'b0;
            reg_wdata_reg <= '0;
            reg_rd_en_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            scl_d_reg     <= scl_f;
            sda_d_reg     <= sda_f;
            reg_wr_en_reg <= 1'b0;
            reg_rd_en_reg <= 1'b0;
            rd_cap_reg    <= reg_rd_en_reg;

            if (rd_cap_reg) tx_sh_reg <= reg_rdata;
            if (reg_wr_en_reg) reg_addr_reg <= reg_addr_reg + ADDR_ONE;

            if (stop_det) begin
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b0;
                bit_cnt_reg <= '0;
                ack_on_reg  <= 1'b0;
            end else if (start_det) begin
                sda_oe_reg  <= 1'b0;
                bit_cnt_reg <= '0;
                ack_on_reg  <= 1'b0;
            end else begin
                if (scl_rise) begin
                    rx_sh_reg   <= byte_in;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                // Every state entry starts a fresh bit count and ACK phase.
                if (state_next != state_reg) begin
                    bit_cnt_reg <= '0;
                    ack_on_reg  <= 1'b0;
                end

                case (state_reg)
                    ST_DEV: begin
                        if (byte_done) begin
                            if (addr_match) begin
                                busy_reg      <= 1'b1;
                                rw_reg        <= sda_f;
                                sub_cnt_reg   <= '0;
                                reg_rd_en_reg <= sda_f;
                            end else begin
                                busy_reg <= 1'b0;
                            end
                        end
                    end
                    ST_ACK_DEV, ST_ACK_SUB, ST_ACK_WR: begin
                        // First fall pulls SDA for the ACK, second fall ends it (or starts read data).
                        if (scl_fall) begin
                            if (!ack_on_reg) begin
                                sda_oe_reg <= 1'b1;
                                ack_on_reg <= 1'b1;
                            end else begin
                                sda_oe_reg <= (state_reg == ST_ACK_DEV && rw_reg) ? ~tx_sh_reg[7] : 1'b0;
                            end
                        end
                    end
                    ST_SUB: begin
                        if (byte_done) begin
                            for (int i = 0; i < ADDR_BYTE; i++) begin
                                if (sub_cnt_reg == 2'(i)) reg_addr_reg[i*8 +: 8] <= byte_in;
                            end
                            sub_cnt_reg <= sub_cnt_reg + 2'd1;
                        end
                    end
                    ST_WR: begin
                        if (byte_done) begin
                            reg_wr_en_reg <= 1'b1;
                            reg_wdata_reg <= byte_in;
                        end
                    end
                    ST_RD: begin
                        if (scl_rise) tx_sh_reg <= {tx_sh_reg[6:0], 1'b1};
                        if (scl_fall) sda_oe_reg <= ~tx_sh_reg[7];
                    end
                    ST_MACK: begin
                        if (scl_fall) sda_oe_reg <= 1'b0;
                        if (scl_rise && !sda_f) begin
                            reg_addr_reg  <= reg_addr_reg + ADDR_ONE;
                            reg_rd_en_reg <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wr_en = reg_wr_en_reg;
    assign reg_wdata = reg_wdata_reg;
    assign reg_rd_en = reg_rd_en_reg;
    assign busy      = busy_reg;

endmodule
